// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES carry-chained chunks, valid/ready with global stall.
// Define PIPE_ADD_SUB_SAT_EN to clamp out_sum to the signed range on overflow.
module pipe_add_sub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic             r_c     [STAGES];
    logic             r_ovf;

    logic             w_vin   [STAGES];
    logic [WIDTH-1:0] w_a     [STAGES];
    logic [WIDTH-1:0] w_b     [STAGES];
    logic             w_ci    [STAGES];
    logic [WIDTH-1:0] w_slo   [STAGES];
    logic [WIDTH-1:0] w_sum_n [STAGES];
    logic [CHUNK:0]   w_add   [STAGES];
    logic             w_advance;
    logic             w_amsb;
    logic             w_ovf;

    // Operand registers hold the not-yet-added upper chunks shifted down, so every
    // stage always adds bits [CHUNK-1:0]; the final stage therefore sees the MSB chunk.
    always_comb begin
        w_advance = !r_valid[LAST] || out_ready;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                w_vin[k] = in_valid;
                w_a[k]   = in_a;
                w_b[k]   = in_sub ? ~in_b : in_b;
                w_ci[k]  = in_sub ? ~in_cin : in_cin;
                w_slo[k] = '0;
            end else begin
                w_vin[k] = r_valid[k-1];
                w_a[k]   = r_a[k-1];
                w_b[k]   = r_b[k-1];
                w_ci[k]  = r_c[k-1];
                w_slo[k] = r_sum[k-1];
            end
            w_add[k] = {1'b0, w_a[k][CHUNK-1:0]} + {1'b0, w_b[k][CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, w_ci[k]};
            w_sum_n[k] = w_slo[k];
            w_sum_n[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
        end
        w_amsb = w_a[LAST][CHUNK-1];
        w_ovf  = (w_amsb == w_b[LAST][CHUNK-1]) && (w_add[LAST][CHUNK-1] != w_amsb);
`ifdef PIPE_ADD_SUB_SAT_EN
        if (w_ovf) begin
            w_sum_n[LAST] = {w_amsb, {(WIDTH-1){~w_amsb}}};
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_sum[k]   <= '0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_c[k]     <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_vin[k];
                r_sum[k]   <= w_sum_n[k];
                r_a[k]     <= w_a[k] >> CHUNK;
                r_b[k]     <= w_b[k] >> CHUNK;
                r_c[k]     <= w_add[k][CHUNK];
            end
            r_ovf <= w_ovf;
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_valid[LAST];
    assign out_sum   = r_sum[LAST];
    assign out_carry = r_c[LAST];
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub (WIDTH=16, STAGES=4): directed plan vectors plus
// randomized traffic scored against an arithmetic reference model.
module tb_pipe_add_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_carry;
    logic        out_ovf;

    always #5 clk = ~clk;

    pipe_add_sub #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          n_sent = 0;
    bit          lat_chk = 1'b0;
    bit          stall_prev = 1'b0;
    bit          rnd_done = 1'b0;
    logic [17:0] held;
    logic [15:0] last_sum;
    logic        last_c;
    logic        last_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        int   ru;
        int   rs;
        if (!sub) begin
            ru  = int'(a) + int'(b) + int'(cin);
            rs  = int'($signed(a)) + int'($signed(b)) + int'(cin);
            e.c = (ru > 65535);
        end else begin
            ru  = int'(a) - int'(b) - int'(cin);
            rs  = int'($signed(a)) - int'($signed(b)) - int'(cin);
            e.c = (ru >= 0);
        end
        e.sum = ru[15:0];
        e.o   = (rs > 32767) || (rs < -32768);
`ifdef PIPE_ADD_SUB_SAT_EN
        if (rs > 32767) e.sum = 16'h7FFF;
        else if (rs < -32768) e.sum = 16'h8000;
`endif
        e.cyc = 0;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({out_carry, out_ovf, out_sum}), 32'(held));
            end
            stall_prev = out_valid && !out_ready;
            held = {out_carry, out_ovf, out_sum};
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sum", 32'(out_sum), 32'(e.sum));
                    check("carry", 32'(out_carry), 32'(e.c));
                    check("ovf", 32'(out_ovf), 32'(e.o));
                    if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'd4);
                    last_sum = out_sum;
                    last_c   = out_carry;
                    last_o   = out_ovf;
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                e = model(in_a, in_b, in_cin, in_sub);
                e.cyc = cyc;
                sb.push_back(e);
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat transferred.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        else n_sent++;
        in_valid = 1'b0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        in_cin = 1'($urandom);
        in_sub = 1'($urandom);
    endtask

    task automatic bubble(input int n);
        in_valid = 1'b0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int out_before;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(posedge clk);
        #1;

        lat_chk = 1'b1;
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        drain();
        check("add_ffff_sum", 32'(last_sum), 32'h0000FFFE);
        check("add_ffff_carry", 32'(last_c), 32'd1);
        check("add_ffff_ovf", 32'(last_o), 32'd0);

        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        drain();
        check("ripple_sum", 32'(last_sum), 32'h00000000);
        check("ripple_carry", 32'(last_c), 32'd1);

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drain();
`ifdef PIPE_ADD_SUB_SAT_EN
        check("posovf_sum", 32'(last_sum), 32'h00007FFF);
`else
        check("posovf_sum", 32'(last_sum), 32'h00008000);
`endif
        check("posovf_ovf", 32'(last_o), 32'd1);
        check("posovf_carry", 32'(last_c), 32'd0);

        send(16'h8000, 16'hFFFF, 1'b0, 1'b0);
        drain();
`ifdef PIPE_ADD_SUB_SAT_EN
        check("negovf_sum", 32'(last_sum), 32'h00008000);
`else
        check("negovf_sum", 32'(last_sum), 32'h00007FFF);
`endif
        check("negovf_ovf", 32'(last_o), 32'd1);
        check("negovf_carry", 32'(last_c), 32'd1);

        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        drain();
        check("sub_borrow_sum", 32'(last_sum), 32'h0000FFFE);
        check("sub_borrow_carry", 32'(last_c), 32'd0);

        send(16'h0007, 16'h0005, 1'b1, 1'b1);
        drain();
        check("sub_cin_sum", 32'(last_sum), 32'h00000001);
        check("sub_cin_carry", 32'(last_c), 32'd1);

        // Backpressure: 8 back-to-back beats, consumer stalls for 4 cycles.
        lat_chk = 1'b0;
        out_before = n_out;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(16'(i), 16'(100 * i), 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 32'(n_out - out_before), 32'd8);
        check("bp_last_sum", 32'(last_sum), 32'd808);

        // Bubbles on alternate cycles keep the 4-cycle spacing.
        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
            bubble(1);
        end
        drain();

        // Reset mid-flight discards the in-flight beats.
        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(out_valid), 32'd0);
            check("post_rst_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        drain();
        check("post_rst_sum", 32'(last_sum), 32'h00002345);

        // Randomized traffic with random consumer backpressure.
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) bubble($urandom_range(1, 2));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("total_beats", 32'(n_out), 32'(n_sent - 3));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
